// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and helpers for FIFO variants
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_READ_STD  = 1'b0,
        FIFO_READ_FWFT = 1'b1
    } fifo_read_mode_e;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_ar.sv
// rtl/fifo_mem_ar.sv - storage array, synchronous write, asynchronous read
module fifo_mem_ar #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with standard or first-word-fall-through read
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int READ_MODE     = 0,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    localparam int PTR_W        = ptr_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    output logic                  o_fifo_full,
    output logic                  o_almost_full,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_valid,
    output logic                  o_fifo_empty,
    output logic                  o_almost_empty,
    output logic [PTR_W-1:0]      o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int AW = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_THRESH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_flex: FIFO_DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
        $error("sync_fifo_flex: AFULL_THRESH out of range");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_flex: AEMPTY_THRESH out of range");
    end
    if (READ_MODE != 0 && READ_MODE != 1) begin : g_bad_mode
        $error("sync_fifo_flex: READ_MODE must be 0 or 1");
    end

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  wr_accept, rd_accept;

    assign o_count        = wr_ptr - rd_ptr;
    assign o_fifo_full    = (o_count == DEPTH_C);
    assign o_fifo_empty   = (o_count == '0);
    assign o_almost_full  = (o_count >= AFULL_C);
    assign o_almost_empty = (o_count <= AEMPTY_C);

    // Flush wins over both requests; acceptance uses the pre-edge full/empty state.
    assign wr_accept = i_wr_en & ~o_fifo_full  & ~i_flush;
    assign rd_accept = i_rd_en & ~o_fifo_empty & ~i_flush;

    fifo_mem_ar #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (i_data_in),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
            if (i_wr_en && o_fifo_full)  o_overflow  <= 1'b1;
            if (i_rd_en && o_fifo_empty) o_underflow <= 1'b1;
        end
    end

    if (READ_MODE == int'(FIFO_READ_FWFT)) begin : g_fwft
        // Memory is never reset, so the head is masked while empty.
        assign o_data_out   = o_fifo_empty ? '0 : mem_rd_data;
        assign o_data_valid = ~o_fifo_empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (i_flush) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_accept;
                if (rd_accept) data_q <= mem_rd_data;
            end
        end

        assign o_data_out   = data_q;
        assign o_data_valid = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - randomized bench comparing standard and FWFT FIFOs against a queue model
module tb_sync_fifo_flex;

    localparam int DW = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_wr_en = 1'b0;
    logic          i_rd_en = 1'b0;
    logic [DW-1:0] i_data_in = '0;

    logic [DW-1:0] s_data, f_data;
    logic          s_valid, f_valid, s_full, f_full, s_afull, f_afull;
    logic          s_empty, f_empty, s_aempty, f_aempty;
    logic          s_ovf, f_ovf, s_unf, f_unf;
    logic [2:0]    s_count, f_count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_sdata;
    logic          m_svalid, m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .READ_MODE(0),
                     .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_std (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .i_wr_en(i_wr_en),
        .i_data_in(i_data_in), .o_fifo_full(s_full), .o_almost_full(s_afull),
        .i_rd_en(i_rd_en), .o_data_out(s_data), .o_data_valid(s_valid),
        .o_fifo_empty(s_empty), .o_almost_empty(s_aempty), .o_count(s_count),
        .o_overflow(s_ovf), .o_underflow(s_unf));

    sync_fifo_flex #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .READ_MODE(1),
                     .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_fwft (
        .clk(clk), .n_rst(n_rst), .i_flush(i_flush), .i_wr_en(i_wr_en),
        .i_data_in(i_data_in), .o_fifo_full(f_full), .o_almost_full(f_afull),
        .i_rd_en(i_rd_en), .o_data_out(f_data), .o_data_valid(f_valid),
        .o_fifo_empty(f_empty), .o_almost_empty(f_aempty), .o_count(f_count),
        .o_overflow(f_ovf), .o_underflow(f_unf));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sdata  = '0;
        m_svalid = 1'b0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, return at the next falling edge.
    task automatic cyc(input bit wr, input bit rd, input bit fl, input logic [DW-1:0] d);
        int cnt;
        i_wr_en   = wr;
        i_rd_en   = rd;
        i_flush   = fl;
        i_data_in = d;
        @(posedge clk);
        cnt = q.size();
        if (fl) begin
            model_reset();
        end else begin
            if (wr && cnt == D) m_ovf = 1'b1;
            if (rd && cnt == 0) m_unf = 1'b1;
            m_svalid = rd && cnt != 0;
            if (m_svalid) m_sdata = q.pop_front();
            if (wr && cnt != D) q.push_back(d);
        end
        @(negedge clk);
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        i_flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int cnt;
            cnt = q.size();
            chk("s_count",  32'(s_count),  32'(cnt));
            chk("f_count",  32'(f_count),  32'(cnt));
            chk("s_empty",  32'(s_empty),  32'(cnt == 0));
            chk("f_empty",  32'(f_empty),  32'(cnt == 0));
            chk("s_full",   32'(s_full),   32'(cnt == D));
            chk("f_full",   32'(f_full),   32'(cnt == D));
            chk("s_afull",  32'(s_afull),  32'(cnt >= AF));
            chk("f_afull",  32'(f_afull),  32'(cnt >= AF));
            chk("s_aempty", 32'(s_aempty), 32'(cnt <= AE));
            chk("f_aempty", 32'(f_aempty), 32'(cnt <= AE));
            chk("s_ovf",    32'(s_ovf),    32'(m_ovf));
            chk("f_ovf",    32'(f_ovf),    32'(m_ovf));
            chk("s_unf",    32'(s_unf),    32'(m_unf));
            chk("f_unf",    32'(f_unf),    32'(m_unf));
            chk("s_data",   32'(s_data),   32'(m_sdata));
            chk("s_valid",  32'(s_valid),  32'(m_svalid));
            chk("f_valid",  32'(f_valid),  32'(cnt != 0));
            if (cnt != 0) chk("f_data", 32'(f_data), 32'(q[0]));
        end
    end

    initial begin
        logic [DW-1:0] wv;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_empty", 32'({s_empty, f_empty, s_aempty, f_aempty}), 32'hF);
        chk("rst_count", 32'({s_count, f_count}), 32'h0);
        chk("rst_data",  32'({s_data, f_data}), 32'h0);
        chk("rst_misc",  32'({s_valid, f_valid, s_ovf, f_ovf, s_unf, f_unf, s_full, s_afull}), 32'h0);
        n_rst = 1'b1;
        chk_en = 1'b1;
        cyc(0, 0, 0, 8'h00);

        // Fill with A1..A4.
        for (int i = 0; i < 4; i++) begin
            wv = 8'hA1 + 8'(i);
            cyc(1, 0, 0, wv);
            chk("fill_count", 32'(s_count), 32'(i + 1));
            if (i == 0) chk("fwft_first", 32'({f_valid, f_data}), 32'h1A1);
            if (i == 2) chk("afull_at3", 32'({s_afull, s_full}), 32'h2);
        end
        chk("full_at4", 32'({s_full, f_full}), 32'h3);

        // Full with both requests: read taken, write dropped.
        cyc(1, 1, 0, 8'hFF);
        chk("ovf_read", 32'({s_valid, s_data}), 32'h1A1);
        chk("ovf_state", 32'({s_count, s_ovf, f_ovf}), 32'({3'd3, 2'b11}));
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 8'h00);
            chk("drain", 32'(s_data), 32'(8'hA2 + 8'(i)));
        end

        // Empty with both requests: write taken, read dropped.
        cyc(1, 1, 0, 8'h5C);
        chk("unf_state", 32'({s_count, s_unf, s_valid, s_data}), 32'({3'd1, 2'b10, 8'hA4}));
        chk("unf_fwft", 32'(f_data), 32'h5C);

        // Steady stream at count 2 across pointer wrap.
        cyc(1, 0, 0, 8'h60);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 8'h70 + 8'(i));
        chk("stream_count", 32'(s_count), 32'd2);
        chk("stream_last", 32'(s_data), 32'h77);

        // Count 3 with sticky errors, then flush alongside a write.
        cyc(1, 0, 0, 8'h90);
        cyc(1, 1, 1, 8'h91);
        chk("flush", 32'({s_count, s_empty, s_ovf, s_unf, s_valid, s_data}), 32'({3'd0, 4'b1000, 8'h00}));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 39) == 0), 8'($urandom));
        end

        // Asynchronous reset between edges.
        cyc(1, 0, 0, 8'h33);
        cyc(1, 0, 0, 8'h34);
        i_wr_en = 1'b1;
        i_rd_en = 1'b1;
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_count", 32'({s_count, f_count}), 32'h0);
        chk("arst_flags", 32'({s_empty, s_aempty, f_empty, f_aempty, s_full, s_afull, f_full, f_afull}), 32'hF0);
        chk("arst_out", 32'({s_data, f_data, s_valid, f_valid, s_ovf, s_unf}), 32'h0);
        model_reset();
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        cyc(1, 0, 0, 8'h42);
        chk("post_rst", 32'({s_count, f_data}), 32'({3'd1, 8'h42}));

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
